// File: rtl/ddr3_phase_pkg.sv
// Shared types and modular phase-position helpers for the PLL phase-step controller.
package ddr3_phase_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STEP    = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_FIN     = 3'd4
  } phase_state_t;

  // Position +1 with wrap from steps-1 back to 0.
  function automatic int unsigned pos_inc(input int unsigned pos, input int unsigned steps);
    return (pos + 32'd1 >= steps) ? 32'd0 : pos + 32'd1;
  endfunction

  // Position -1 with wrap from 0 back to steps-1.
  function automatic int unsigned pos_dec(input int unsigned pos, input int unsigned steps);
    return (pos == 32'd0) ? steps - 32'd1 : pos - 32'd1;
  endfunction

endpackage

// File: rtl/ddr3_phase_timer.sv
// Loadable saturating down-counter; expired_o is high while the count sits at zero.
module ddr3_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         expired_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Expire flag is registered from the next count so it lines up with cnt_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == '0);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/ddr3_phase_step_ctrl.sv
// Issues N single PLL phase steps with a phase_done handshake per step and
// tracks the absolute phase position modulo one clock period.
module ddr3_phase_step_ctrl
  import ddr3_phase_pkg::*;
#(
  parameter int unsigned PHASE_STEPS  = 56,
  parameter int unsigned COUNT_W      = 8,
  parameter int unsigned STEP_HOLD    = 2,
  parameter int unsigned DONE_TIMEOUT = 64,
  parameter int unsigned POS_W        = $clog2(PHASE_STEPS)
) (
  input  logic               CLK_IN,
  input  logic               RST_IN,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_updn,
  input  logic [COUNT_W-1:0] req_count,
  output logic               busy,
  output logic               seq_done,
  output logic               timeout_err,
  output logic [POS_W-1:0]   phase_pos,
  output logic               phase_step,
  output logic               phase_updn,
  input  logic               phase_done
);

  localparam int unsigned TMR_MAX = (STEP_HOLD > DONE_TIMEOUT) ? STEP_HOLD : DONE_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  phase_state_t       state_q, state_d;
  logic [COUNT_W-1:0] remain_q, remain_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               updn_q, updn_d;
  logic               terr_q, terr_d;
  logic               step_q, step_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;

  logic               tmr_load, tmr_dec, tmr_exp;
  logic [TMR_W-1:0]   tmr_val;

  ddr3_phase_timer #(.W(TMR_W)) u_timer (
    .clk_i      (CLK_IN),
    .rst_i      (RST_IN),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .expired_o  (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    pos_d    = pos_q;
    updn_d   = updn_q;
    terr_d   = terr_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          updn_d   = req_updn;
          remain_d = req_count;
          terr_d   = 1'b0;
          if (req_count == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d  = S_STEP;
            step_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(STEP_HOLD - 1);
          end
        end
      end

      S_STEP: begin
        if (tmr_exp) begin
          state_d  = S_WAIT_LO;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(DONE_TIMEOUT - 1);
        end else begin
          step_d  = 1'b1;
          tmr_dec = 1'b1;
        end
      end

      // The timeout budget spans both wait states; the timer is not reloaded between them.
      S_WAIT_LO: begin
        if (!phase_done) begin
          state_d = S_WAIT_HI;
          tmr_dec = 1'b1;
        end else if (tmr_exp) begin
          state_d  = S_FIN;
          done_d   = 1'b1;
          terr_d   = 1'b1;
          remain_d = '0;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      S_WAIT_HI: begin
        if (phase_done) begin
          pos_d    = updn_q ? POS_W'(pos_inc(32'(pos_q), PHASE_STEPS))
                            : POS_W'(pos_dec(32'(pos_q), PHASE_STEPS));
          remain_d = remain_q - COUNT_W'(1);
          if (remain_q == COUNT_W'(1)) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d  = S_STEP;
            step_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(STEP_HOLD - 1);
          end
        end else if (tmr_exp) begin
          state_d  = S_FIN;
          done_d   = 1'b1;
          terr_d   = 1'b1;
          remain_d = '0;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      pos_q    <= '0;
      updn_q   <= 1'b0;
      terr_q   <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      pos_q    <= pos_d;
      updn_q   <= updn_d;
      terr_q   <= terr_d;
      step_q   <= step_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign seq_done    = done_q;
  assign timeout_err = terr_q;
  assign phase_pos   = pos_q;
  assign phase_step  = step_q;
  assign phase_updn  = updn_q;

endmodule
